pq_write_arbiter: RTL and testbench

Shares the P/Q register pair between two information-controller requesters (ch0, ch1).
- Arbitration is round-robin; one write is committed per grant.
- The target register is chosen by the requester's select bit (0 = P, 1 = Q).
- Per-channel trap events are counted; a channel that reaches LOCK_LIMIT traps is locked out until reset.

---
 rtl/pq_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_pq_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pq_write_arbiter.sv
// rtl/pq_write_arbiter.sv - round-robin P/Q register write arbiter with per-channel trap lockout
// Optional PQ_ARB_WRCOUNT_EN adds a saturating wr_count of completed commits.
module pq_write_arbiter #(
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 16,
  parameter int LOCK_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic              sel0,
  input  logic              sel1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              trap0,
  input  logic              trap1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] regP,
  output logic [DATA_W-1:0] regQ,
  output logic              lock0,
  output logic              lock1,
`ifdef PQ_ARB_WRCOUNT_EN
  output logic [15:0]       wr_count,
`endif
  output logic              busy
);

  localparam int            TW   = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LIM  = 4'(LOCK_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, COMMIT} state_t;

  state_t              state, state_nx;
  logic                last_served, last_nx;
  logic                capture;
  logic                cap_sel;
  logic [DATA_W-1:0]   cap_data;
  logic                stg_sel;
  logic [DATA_W-1:0]   stg_data;
  logic [TW-1:0]       timer;
  logic [3:0]          cnt0, cnt1, cnt0_nx, cnt1_nx;
  logic                elig0, elig1;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);
  assign busy = (state != IDLE);

  assign elig0 = req0 & ~lock0;
  assign elig1 = req1 & ~lock1;

  assign cnt0_nx = (trap0 && cnt0 != LIM) ? cnt0 + 4'd1 : cnt0;
  assign cnt1_nx = (trap1 && cnt1 != LIM) ? cnt1 + 4'd1 : cnt1;

  always_comb begin
    state_nx = state;
    last_nx  = last_served;
    capture  = 1'b0;
    cap_sel  = sel0;
    cap_data = data0;
    case (state)
      IDLE: begin
        // On a tie, last_served == 1 means ch0's turn.
        if (elig0 && (!elig1 || last_served)) state_nx = GNT0;
        else if (elig1)                       state_nx = GNT1;
      end
      GNT0: begin
        if (trap0 || !req0) begin
          state_nx = IDLE;
        end else if (wr_en0) begin
          state_nx = COMMIT;
          capture  = 1'b1;
          last_nx  = 1'b0;
        end else if (timer == TMAX) begin
          state_nx = IDLE;
          last_nx  = 1'b0;
        end
      end
      GNT1: begin
        cap_sel  = sel1;
        cap_data = data1;
        if (trap1 || !req1) begin
          state_nx = IDLE;
        end else if (wr_en1) begin
          state_nx = COMMIT;
          capture  = 1'b1;
          last_nx  = 1'b1;
        end else if (timer == TMAX) begin
          state_nx = IDLE;
          last_nx  = 1'b1;
        end
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      timer       <= '0;
      stg_sel     <= 1'b0;
      stg_data    <= '0;
      regP        <= '0;
      regQ        <= '0;
      cnt0        <= '0;
      cnt1        <= '0;
      lock0       <= 1'b0;
      lock1       <= 1'b0;
`ifdef PQ_ARB_WRCOUNT_EN
      wr_count    <= '0;
`endif
    end else begin
      state       <= state_nx;
      last_served <= last_nx;
      // Only meaningful while granted; restarts on every state change.
      timer       <= (state_nx != state) ? '0 : timer + 1'b1;
      if (capture) begin
        stg_sel  <= cap_sel;
        stg_data <= cap_data;
      end
      if (state == COMMIT) begin
        if (stg_sel) regQ <= stg_data;
        else         regP <= stg_data;
`ifdef PQ_ARB_WRCOUNT_EN
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
      end
      cnt0  <= cnt0_nx;
      cnt1  <= cnt1_nx;
      lock0 <= (cnt0_nx == LIM);
      lock1 <= (cnt1_nx == LIM);
    end
  end

endmodule

// File: tb/tb_pq_write_arbiter.sv
// tb/tb_pq_write_arbiter.sv - vector table plus hand sequences with a commit scoreboard for pq_write_arbiter
module tb_pq_write_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, req1 = 0, wr_en0 = 0, wr_en1 = 0, sel0 = 0, sel1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic       trap0 = 0, trap1 = 0;
  logic       gnt0, gnt1, lock0, lock1, busy;
  logic [7:0] regP, regQ;
`ifdef PQ_ARB_WRCOUNT_EN
  logic [15:0] wr_count;
`endif

  pq_write_arbiter #(.DATA_W(8), .TIMEOUT(16), .LOCK_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .wr_en0(wr_en0), .wr_en1(wr_en1),
    .sel0(sel0), .sel1(sel1), .data0(data0), .data1(data1),
    .trap0(trap0), .trap1(trap1),
    .gnt0(gnt0), .gnt1(gnt1), .regP(regP), .regQ(regQ),
    .lock0(lock0), .lock1(lock1),
`ifdef PQ_ARB_WRCOUNT_EN
    .wr_count(wr_count),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] ctl;   // req0 req1 wr_en0 wr_en1 sel0 sel1
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] trap;  // trap0 trap1
    logic [4:0] exp;   // gnt0 gnt1 busy lock0 lock1
    logic       push;
    logic       psel;
    logic [7:0] pdata;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [7:0] data;
  } wr_t;

  wr_t  sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_commit = 0;
  vec_t vt[28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] trap, input logic [4:0] exp,
                              input logic push, input logic psel, input logic [7:0] pdata);
    vec_t v;
    v.ctl = ctl; v.d0 = d0; v.d1 = d1; v.trap = trap; v.exp = exp;
    v.push = push; v.psel = psel; v.pdata = pdata;
    return v;
  endfunction

  // Commit monitor: the edge after a COMMIT cycle must apply the oldest expected write,
  // every other non-reset edge must leave both registers untouched.
  logic       p_commit = 1'b0;
  logic [7:0] p_P = 8'h00, p_Q = 8'h00;
  logic       rst_s;
  always @(posedge clock) begin
    wr_t e;
    rst_s = reset;
    #1;
    chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
    if (!rst_s) begin
      if (p_commit) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          n_commit++;
          chk("sb_regP", {24'd0, regP}, {24'd0, e.sel ? p_P : e.data});
          chk("sb_regQ", {24'd0, regQ}, {24'd0, e.sel ? e.data : p_Q});
        end
      end else begin
        chk("regP_hold", {24'd0, regP}, {24'd0, p_P});
        chk("regQ_hold", {24'd0, regQ}, {24'd0, p_Q});
      end
    end
    p_commit = busy & ~gnt0 & ~gnt1;
    p_P = regP;
    p_Q = regQ;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = mk(6'b100000, 8'h00, 8'h00, 2'b00, 5'b10100, 1'b0, 1'b0, 8'h00);
    vt[1]  = mk(6'b101000, 8'hA5, 8'h00, 2'b00, 5'b00100, 1'b1, 1'b0, 8'hA5);
    vt[2]  = mk(6'b000000, 8'h00, 8'h00, 2'b00, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[3]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b01100, 1'b0, 1'b0, 8'h00);
    vt[4]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00100, 1'b1, 1'b1, 8'h22);
    vt[5]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[6]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b10100, 1'b0, 1'b0, 8'h00);
    vt[7]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00100, 1'b1, 1'b0, 8'h11);
    vt[8]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[9]  = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b01100, 1'b0, 1'b0, 8'h00);
    vt[10] = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00100, 1'b1, 1'b1, 8'h22);
    vt[11] = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[12] = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b10100, 1'b0, 1'b0, 8'h00);
    vt[13] = mk(6'b111101, 8'h11, 8'h22, 2'b00, 5'b00100, 1'b1, 1'b0, 8'h11);
    vt[14] = mk(6'b000000, 8'h00, 8'h00, 2'b00, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[15] = mk(6'b000000, 8'h00, 8'h00, 2'b10, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[16] = mk(6'b000000, 8'h00, 8'h00, 2'b10, 5'b00000, 1'b0, 1'b0, 8'h00);
    vt[17] = mk(6'b000000, 8'h00, 8'h00, 2'b10, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[18] = mk(6'b100000, 8'h00, 8'h00, 2'b00, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[19] = mk(6'b110000, 8'h00, 8'h00, 2'b00, 5'b01110, 1'b0, 1'b0, 8'h00);
    vt[20] = mk(6'b110100, 8'h00, 8'h33, 2'b00, 5'b00110, 1'b1, 1'b0, 8'h33);
    vt[21] = mk(6'b110000, 8'h00, 8'h00, 2'b00, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[22] = mk(6'b110000, 8'h00, 8'h00, 2'b00, 5'b01110, 1'b0, 1'b0, 8'h00);
    vt[23] = mk(6'b100000, 8'h00, 8'h00, 2'b00, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[24] = mk(6'b100000, 8'h00, 8'h00, 2'b00, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[25] = mk(6'b010000, 8'h00, 8'h00, 2'b00, 5'b01110, 1'b0, 1'b0, 8'h00);
    vt[26] = mk(6'b010101, 8'h00, 8'hEE, 2'b01, 5'b00010, 1'b0, 1'b0, 8'h00);
    vt[27] = mk(6'b000000, 8'h00, 8'h00, 2'b00, 5'b00010, 1'b0, 1'b0, 8'h00);

    step();
    step();
    chk("rst_gnt",   {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_lock",  {30'd0, lock0, lock1}, 32'd0);
    chk("rst_regP",  {24'd0, regP}, 32'd0);
    chk("rst_regQ",  {24'd0, regQ}, 32'd0);
`ifdef PQ_ARB_WRCOUNT_EN
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
`endif
    reset = 1'b0;

    // Single write, round-robin alternation, lockout and trap-beats-write.
    for (int i = 0; i < 28; i++) begin
      {req0, req1, wr_en0, wr_en1, sel0, sel1} = vt[i].ctl;
      data0 = vt[i].d0;
      data1 = vt[i].d1;
      {trap0, trap1} = vt[i].trap;
      if (vt[i].push) sb.push_back('{sel: vt[i].psel, data: vt[i].pdata});
      step();
      chk($sformatf("vec%0d_outs", i), {27'd0, gnt0, gnt1, busy, lock0, lock1}, {27'd0, vt[i].exp});
    end
    {req0, req1, wr_en0, wr_en1, sel0, sel1, trap0, trap1} = '0;
    chk("final_regP", {24'd0, regP}, 32'h33);
    chk("final_regQ", {24'd0, regQ}, 32'h22);
    chk("commits_done", n_commit, 6);
`ifdef PQ_ARB_WRCOUNT_EN
    chk("wr_count_6", {16'd0, wr_count}, 32'd6);
`endif

    // Reset clears lockout; ch0 is served again.
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_commit = 0;
    chk("lock0_cleared", {31'd0, lock0}, 32'd0);
    chk("regP_reset", {24'd0, regP}, 32'd0);
    req0 = 1'b1;
    step();
    chk("gnt0_after_unlock", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    step();
    chk("idle_after_drop", {31'd0, busy}, 32'd0);

    // Grant timeout: gnt1 held exactly TIMEOUT cycles, then ch0 served.
    req1 = 1'b1;
    step();
    chk("gnt1_start", {31'd0, gnt1}, 32'd1);
    req0 = 1'b1;
    n = 0;
    while (gnt1 === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_idle", {30'd0, gnt0, busy}, 32'd0);
    step();
    chk("gnt0_after_timeout", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    step();
    chk("timeout_regQ", {24'd0, regQ}, 32'd0);

    // Reset during COMMIT discards the staged write.
    req1 = 1'b1;
    step();
    chk("gnt1_for_7e", {31'd0, gnt1}, 32'd1);
    wr_en1 = 1'b1; sel1 = 1'b1; data1 = 8'h7E;
    step();
    chk("commit_7e", {30'd0, gnt1, busy}, 32'd1);
    reset = 1'b1; wr_en1 = 1'b0; req1 = 1'b0;
    step();
    chk("rst_commit_regQ", {24'd0, regQ}, 32'd0);
    chk("rst_commit_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_regQ", {24'd0, regQ}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
`ifdef PQ_ARB_WRCOUNT_EN
    chk("wr_count_rst", {16'd0, wr_count}, 32'd0);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
